// File: rtl/dbus_responder_if.sv
// rtl/dbus_responder_if.sv - dbus request/response types and the core-to-memory bus interface.
package dbus_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

interface dbus_responder_if;
  import dbus_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_responder.sv
// rtl/dbus_responder.sv - memory-side dbus responder: one transaction at a time, fixed latency.
module dbus_responder
  import dbus_pkg::*;
#(
  parameter int          DEPTH   = 4096,
  parameter int          LATENCY = 2,
  parameter logic [63:0] BASE    = 64'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  dbus_responder_if.slave   dbus,
  output logic              busy,
  output logic [31:0]       txn_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  strobe_q;
  logic [2:0]  size_q;
  logic [63:0] rdata_q;
  logic [31:0] count_q;

  logic [63:0] mem [DEPTH];

  // In IDLE the live request is decoded so a LATENCY==1 build can capture read data on the accept edge.
  logic [63:0] cur_addr;
  logic [7:0]  cur_strobe;
  logic [63:0] off;
  logic        in_range;
  logic [AW-1:0] idx;
  logic [63:0] rd_word;
  logic [63:0] capture;

  always_comb begin
    cur_addr   = (state_q == IDLE) ? dbus.dreq.addr   : addr_q;
    cur_strobe = (state_q == IDLE) ? dbus.dreq.strobe : strobe_q;
    off        = cur_addr - BASE;
    in_range   = (cur_addr >= BASE) && ((off >> 3) < 64'(DEPTH));
    idx        = off[3 +: AW];
    rd_word    = in_range ? mem[idx] : 64'hDEAD_BEEF_DEAD_BEEF;
    capture    = (cur_strobe == 8'h00) ? rd_word : 64'h0;
  end

  dbus_resp_t resp;
  always_comb begin
    resp.addr_ok = rst && (state_q == IDLE) && dbus.dreq.valid;
    resp.data_ok = (state_q == RESP);
    resp.data    = rdata_q;
  end
  assign dbus.dresp = resp;
  assign busy       = (state_q != IDLE);
  assign txn_count  = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 64'h0;
      wdata_q  <= 64'h0;
      strobe_q <= 8'h0;
      size_q   <= 3'd0;
      rdata_q  <= 64'h0;
      count_q  <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dbus.dreq.valid) begin
            addr_q   <= dbus.dreq.addr;
            wdata_q  <= dbus.dreq.data;
            strobe_q <= dbus.dreq.strobe;
            size_q   <= dbus.dreq.size;
            if (LATENCY == 1) begin
              state_q <= RESP;
              rdata_q <= capture;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
            rdata_q <= capture;
          end
          cnt_q <= cnt_q - 4'd1;
        end
        RESP: begin
          state_q <= IDLE;
          rdata_q <= 64'h0;
          count_q <= count_q + 32'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The array is never reset; a reset drops state_q to IDLE, which is what suppresses a pending commit.
  always_ff @(posedge clk) begin
    if (state_q == RESP && strobe_q != 8'h00 && in_range) begin
      for (int b = 0; b < 8; b++) begin
        if (strobe_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/dbus_responder.md
Name: dbus_responder

Overview:
- Data-bus responder: the memory-side end of the dbus request/response protocol that the CPU core drives.
- Accepts one dbus_req_t transaction at a time and performs byte-strobed writes or 64-bit word reads on an internal word-addressed memory array.
- Returns dbus_resp_t after a programmable latency.
- Used as the simulation data memory behind the core, and as the bench target for the core's load/store path.

Parameters:
- DEPTH, 4096, number of 64-bit words in the memory array (power of two).
- LATENCY, 2, cycles from request acceptance to the data_ok cycle (1..15).
- BASE, 64'h8000_0000, byte address mapped to word 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- dreq  input  dbus_req_t  request from the core, with fields:
  - valid 1
  - addr 64
  - size 3
  - strobe 8
  - data 64
- dresp  output  dbus_resp_t  response to the core, with fields:
  - addr_ok 1
  - data_ok 1
  - data 64
- busy  output  1  high while a transaction is in flight (state != IDLE).
- txn_count  output  32  count of completed transactions; wraps.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, dresp.addr_ok=0, dresp.data_ok=0, dresp.data=0, busy=0, txn_count=0.
  - Latched request registers are cleared.
  - Memory contents are not modified.
  - Reset mid-transaction aborts it: no write commit and no data_ok.
- State IDLE:
  - dresp.addr_ok = dreq.valid (combinational, this cycle only).
  - On a clock edge with dreq.valid=1: latch addr, strobe and data. Go to WAIT with cnt=LATENCY-1, or straight to RESP if LATENCY==1.
- State WAIT: cnt decrements each cycle; when cnt==0, next state is RESP.
- Read data capture: on the edge entering RESP for a read (latched strobe==0), register mem[idx] into the response data register.
- State RESP:
  - dresp.data_ok=1 for exactly one cycle; dresp.data = captured word for reads, 0 for writes.
  - On the edge leaving RESP:
    - Write commit: mem[idx] byte lane b is updated from data[8b+7:8b] for each set strobe[b].
    - txn_count increments.
    - Next state is IDLE.
- Accept-to-data_ok latency is exactly LATENCY cycles; data_ok asserts on cycle LATENCY after the accepting edge.
- Minimum issue interval is LATENCY+1 cycles. A request still valid in the IDLE cycle after data_ok is treated as a new transaction.
- Index: idx = (addr - BASE) >> 3, taking log2(DEPTH) bits.
  - addr[2:0] is ignored; the full aligned word is returned and strobe alone selects the written bytes.
  - size is latched but not used.
- Out of range (addr < BASE or idx >= DEPTH):
  - Writes are dropped.
  - Reads return 64'hDEAD_BEEF_DEAD_BEEF.
  - The handshake and latency are unchanged.
- dreq changes while busy are ignored; only the latched copy is used.
- addr_ok is 0 outside IDLE.
- Strobe 8'h00 is a read; any nonzero strobe is a write, including partial strobes.
- txn_count wraps from 32'hFFFF_FFFF to 0 without any flag.

Test Plan:
- Full write then read, LATENCY=2: write addr=BASE+8, strobe=8'hFF, data=64'h1122_3344_5566_7788, then read the same address.
  - addr_ok high in each accept cycle.
  - data_ok exactly 2 cycles after each accept.
  - Read returns 64'h1122_3344_5566_7788; txn_count=2.
- Byte-lane merge: after the previous write, write strobe=8'h0F, data=64'hAAAA_AAAA_BBBB_BBBB, then read the same address.
  - Read returns 64'h1122_3344_BBBB_BBBB.
- Out of range: write then read at addr=BASE+DEPTH*8.
  - Both complete with data_ok.
  - Read returns 64'hDEAD_BEEF_DEAD_BEEF.
  - mem[0] is unchanged.
- Back-to-back requests: hold valid continuously with two reads at different addresses.
  - Second addr_ok occurs in the IDLE cycle immediately after the first data_ok.
  - Each data_ok is a single-cycle pulse.
  - busy is low only in that IDLE cycle.
- Reset mid-write: drop rst one cycle after a write is accepted, release rst, then read the same address.
  - Outputs go to 0 immediately, asynchronously.
  - Read returns the old value; txn_count=1 (the read only).
- LATENCY=1 build: data_ok asserts on the cycle after acceptance.
- Hold dreq.addr changing during WAIT: the response still reflects the latched address.
